// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha20 block core.
// Holds the word type, the sigma constants, the round count and the FSM state encoding.
package chacha_pkg;

    typedef logic [31:0] word_t;

    localparam word_t SIGMA0 = 32'h61707865;
    localparam word_t SIGMA1 = 32'h3320646e;
    localparam word_t SIGMA2 = 32'h79622d32;
    localparam word_t SIGMA3 = 32'h6b206574;

    localparam int ROUNDS = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        ADD   = 2'd2,
        OUT   = 2'd3
    } state_t;

    function automatic word_t rotl(input word_t x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha_quarter_round.sv
// Combinational ChaCha quarter-round: add, xor, rotate by 16, 12, 8, 7.
module chacha_quarter_round
    import chacha_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  word_t c,
    input  word_t d,
    output word_t a_next,
    output word_t b_next,
    output word_t c_next,
    output word_t d_next
);

    word_t a1, b1, c1, d1;

    always_comb begin
        a1     = a + b;
        d1     = rotl(d ^ a1, 16);
        c1     = c + d1;
        b1     = rotl(b ^ c1, 12);
        a_next = a1 + b1;
        d_next = rotl(d1 ^ a_next, 8);
        c_next = c1 + d_next;
        b_next = rotl(b1 ^ c_next, 7);
    end

endmodule

// File: rtl/chacha20_block_core.sv
// ChaCha20 block function: one round per cycle, feed-forward add, then a registered
// keystream matrix handed to the serialiser; NUM_MATRICES blocks per start.
module chacha20_block_core
    import chacha_pkg::*;
#(
    parameter int NUM_MATRICES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  word_t [7:0]      key,
    input  word_t [2:0]      nonce,
    input  word_t            counter,
    input  logic             ser_ready,
    output word_t [3:0][3:0] indata_out,
    output logic             load_en,
    output logic             busy,
    output logic             ctr_ovf,
    output state_t           state_dbg
);

    localparam int BLK_W = (NUM_MATRICES > 1) ? $clog2(NUM_MATRICES) : 1;
    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_MATRICES - 1);

    state_t            state, state_next;
    logic [4:0]        rnd;
    logic [BLK_W-1:0]  blk;
    word_t [7:0]       key_q;
    word_t [2:0]       nonce_q;
    word_t             ctr_q;
    word_t [15:0]      work, work_rnd, sum;
    word_t [15:0]      init_start, init_now, init_next;
    word_t [3:0]       qa, qb, qc, qd, qa_n, qb_n, qc_n, qd_n;
    logic [3:0][3:0][3:0] idx;
    logic              transfer, last_round;

    function automatic logic [15:0][31:0] build_state(input word_t [7:0] k,
                                                      input word_t [2:0] n,
                                                      input word_t c);
        logic [15:0][31:0] s;
        s[0] = SIGMA0;
        s[1] = SIGMA1;
        s[2] = SIGMA2;
        s[3] = SIGMA3;
        for (int i = 0; i < 8; i++) s[4+i] = k[i];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13+i] = n[i];
        return s;
    endfunction

    assign init_start = build_state(key, nonce, counter);
    assign init_now   = build_state(key_q, nonce_q, ctr_q);
    assign init_next  = build_state(key_q, nonce_q, ctr_q + 32'd1);
    assign transfer   = (state == OUT) && load_en && ser_ready;
    assign last_round = (rnd == 5'(ROUNDS - 1));
    assign state_dbg  = state;

    // Word k of quarter-round q: row k, column q (column round) or q+k (diagonal round).
    always_comb begin
        idx = '0;
        for (int q = 0; q < 4; q++) begin
            for (int k = 0; k < 4; k++) begin
                idx[q][k] = 4'(4 * k + ((q + (rnd[0] ? k : 0)) & 3));
            end
        end
        for (int q = 0; q < 4; q++) begin
            qa[q] = work[idx[q][0]];
            qb[q] = work[idx[q][1]];
            qc[q] = work[idx[q][2]];
            qd[q] = work[idx[q][3]];
        end
    end

    for (genvar q = 0; q < 4; q++) begin : g_qr
        chacha_quarter_round u_qr (
            .a      (qa[q]),
            .b      (qb[q]),
            .c      (qc[q]),
            .d      (qd[q]),
            .a_next (qa_n[q]),
            .b_next (qb_n[q]),
            .c_next (qc_n[q]),
            .d_next (qd_n[q])
        );
    end

    always_comb begin
        work_rnd = work;
        for (int q = 0; q < 4; q++) begin
            work_rnd[idx[q][0]] = qa_n[q];
            work_rnd[idx[q][1]] = qb_n[q];
            work_rnd[idx[q][2]] = qc_n[q];
            work_rnd[idx[q][3]] = qd_n[q];
        end
        for (int i = 0; i < 16; i++) sum[i] = work[i] + init_now[i];
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = ROUND;
            ROUND:   if (last_round) state_next = ADD;
            ADD:     state_next = OUT;
            OUT:     if (transfer) state_next = (blk == LAST_BLK) ? IDLE : ROUND;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Outputs are flops fed from the next state so nothing depends combinationally on ser_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rnd        <= '0;
            blk        <= '0;
            key_q      <= '0;
            nonce_q    <= '0;
            ctr_q      <= '0;
            work       <= '0;
            indata_out <= '0;
            load_en    <= 1'b0;
            busy       <= 1'b0;
            ctr_ovf    <= 1'b0;
        end else begin
            busy    <= (state_next != IDLE);
            load_en <= (state_next == OUT);
            case (state)
                IDLE: begin
                    if (start) begin
                        key_q   <= key;
                        nonce_q <= nonce;
                        ctr_q   <= counter;
                        work    <= init_start;
                        rnd     <= '0;
                        blk     <= '0;
                        ctr_ovf <= 1'b0;
                    end
                end
                ROUND: begin
                    work <= work_rnd;
                    rnd  <= rnd + 5'd1;
                end
                ADD: indata_out <= sum;
                OUT: begin
                    if (transfer && (blk != LAST_BLK)) begin
                        ctr_q <= ctr_q + 32'd1;
                        work  <= init_next;
                        blk   <= blk + BLK_W'(1);
                        rnd   <= '0;
                        if (ctr_q == 32'hFFFF_FFFF) ctr_ovf <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chacha20_block_core.sv
// Bench for chacha20_block_core: vector table, quarter-round check, backpressure,
// counter wrap, start-while-busy and mid-run reset sequences.
module tb_chacha20_block_core;
    import chacha_pkg::*;

    typedef struct {
        logic [7:0][31:0]  key;
        logic [2:0][31:0]  nonce;
        logic [31:0]       ctr;
        logic [15:0][31:0] exp0;
        logic [15:0][31:0] exp1;
        int                bp;
        int                glitch;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   start = 1'b0;
    logic [7:0][31:0]       key = '0;
    logic [2:0][31:0]       nonce = '0;
    logic [31:0]            counter = '0;
    logic                   ser_ready = 1'b1;
    logic [3:0][3:0][31:0]  indata_out;
    logic                   load_en, busy, ctr_ovf;
    state_t                 dbg_state;

    logic [31:0] qa, qb, qc, qd, qa_n, qb_n, qc_n, qd_n;

    int total = 0;
    int bad = 0;
    int xfers = 0;
    logic [511:0] exp_q[$];
    vec_t tbl[5];

    always #5 clk = ~clk;

    chacha20_block_core #(.NUM_MATRICES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key        (key),
        .nonce      (nonce),
        .counter    (counter),
        .ser_ready  (ser_ready),
        .indata_out (indata_out),
        .load_en    (load_en),
        .busy       (busy),
        .ctr_ovf    (ctr_ovf),
        .state_dbg  (dbg_state)
    );

    chacha_quarter_round u_qr (
        .a(qa), .b(qb), .c(qc), .d(qd),
        .a_next(qa_n), .b_next(qb_n), .c_next(qc_n), .d_next(qd_n)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        logic [63:0] t;
        t = {v, v} << n;
        return t[63:32];
    endfunction

    function automatic logic [15:0][31:0] qr(input logic [15:0][31:0] s,
                                             input int a, input int b, input int c, input int d);
        s[a] = s[a] + s[b]; s[d] = rl(s[d] ^ s[a], 16);
        s[c] = s[c] + s[d]; s[b] = rl(s[b] ^ s[c], 12);
        s[a] = s[a] + s[b]; s[d] = rl(s[d] ^ s[a], 8);
        s[c] = s[c] + s[d]; s[b] = rl(s[b] ^ s[c], 7);
        return s;
    endfunction

    function automatic logic [15:0][31:0] ref_block(input logic [7:0][31:0] k,
                                                    input logic [2:0][31:0] n,
                                                    input logic [31:0] c);
        logic [15:0][31:0] s, x;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[i];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13+i] = n[i];
        x = s;
        for (int r = 0; r < 10; r++) begin
            x = qr(x, 0, 4, 8, 12); x = qr(x, 1, 5, 9, 13);
            x = qr(x, 2, 6, 10, 14); x = qr(x, 3, 7, 11, 15);
            x = qr(x, 0, 5, 10, 15); x = qr(x, 1, 6, 11, 12);
            x = qr(x, 2, 7, 8, 13); x = qr(x, 3, 4, 9, 14);
        end
        for (int i = 0; i < 16; i++) x[i] = x[i] + s[i];
        return x;
    endfunction

    // Scoreboard: a matrix is consumed when load_en and ser_ready are both seen high.
    always @(negedge clk) begin
        if (rst && load_en && ser_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_xfer: got %0h want no transfer", indata_out);
            end else begin
                logic [511:0] e;
                e = exp_q.pop_front();
                if (indata_out !== e) begin
                    bad++;
                    $display("FAIL matrix: got %0h want %0h", indata_out, e);
                end
            end
            xfers++;
        end
    end

    task automatic run_vec(input vec_t v);
        int k, m, x0;
        logic seen_low, stable;
        logic [511:0] held;
        x0 = xfers;
        @(posedge clk); #1;
        key = v.key; nonce = v.nonce; counter = v.ctr; start = 1'b1;
        ser_ready = (v.bp == 0);
        exp_q.push_back(v.exp0);
        exp_q.push_back(v.exp1);
        @(posedge clk); #1;
        start = 1'b0;
        check("ovf_clear_on_start", ctr_ovf, 1'b0);
        check("busy_rise", busy, 1'b1);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (load_en) break;
            if (v.glitch != 0 && k == 5) begin
                start = 1'b1; key = ~v.key; nonce = ~v.nonce; counter = ~v.ctr;
            end
            if (v.glitch != 0 && k == 6) start = 1'b0;
        end
        check("latency", k, 21);
        if (v.bp > 0) begin
            held = indata_out;
            stable = 1'b1;
            repeat (v.bp) begin
                @(negedge clk);
                if (!load_en || indata_out !== held) stable = 1'b0;
            end
            check("bp_hold", stable, 1'b1);
            @(posedge clk); #1;
            ser_ready = 1'b1;
        end else begin
            seen_low = 1'b0;
            for (m = 1; m < 100; m++) begin
                @(negedge clk);
                if (!load_en) seen_low = 1'b1;
                else if (seen_low) break;
            end
            check("spacing", m, 22);
        end
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("busy_fall", busy, 1'b0);
        check("ctr_ovf", ctr_ovf, v.ctr == 32'hFFFF_FFFF);
        check("end_state", dbg_state, IDLE);
        repeat (3) @(negedge clk);
        check("xfer_count", xfers - x0, 2);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [31:0] rfc_w[16];
        rfc_w = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                  32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                  32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                  32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

        qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
        #1;
        check("qr_a", qa_n, 32'hea2a92f4);
        check("qr_b", qb_n, 32'hcb1cf8ce);
        check("qr_c", qc_n, 32'h4581472e);
        check("qr_d", qd_n, 32'h5881c4bb);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_indata", indata_out, '0);
        check("rst_load_en", load_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ctr_ovf", ctr_ovf, 1'b0);
        check("rst_state", dbg_state, IDLE);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 8; j++) tbl[i].key[j] = $urandom();
            for (int j = 0; j < 3; j++) tbl[i].nonce[j] = $urandom();
            tbl[i].ctr = $urandom_range(0, 32'h7fff_ffff);
            tbl[i].bp = 0;
            tbl[i].glitch = 0;
        end
        for (int j = 0; j < 8; j++)
            tbl[0].key[j] = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
        tbl[0].nonce[0] = 32'h09000000;
        tbl[0].nonce[1] = 32'h4a000000;
        tbl[0].nonce[2] = 32'h00000000;
        tbl[0].ctr = 32'd1;
        tbl[1].glitch = 1;
        tbl[2].ctr = 32'hFFFF_FFFF;
        tbl[3].bp = 10;
        tbl[4].bp = $urandom_range(3, 8);
        for (int i = 0; i < 5; i++) begin
            tbl[i].exp0 = ref_block(tbl[i].key, tbl[i].nonce, tbl[i].ctr);
            tbl[i].exp1 = ref_block(tbl[i].key, tbl[i].nonce, tbl[i].ctr + 32'd1);
        end
        for (int j = 0; j < 16; j++) tbl[0].exp0[j] = rfc_w[j];

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Abort in the middle of the rounds: no matrix may come out.
        @(posedge clk); #1;
        key = tbl[0].key; nonce = tbl[0].nonce; counter = tbl[0].ctr;
        ser_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_indata", indata_out, '0);
        check("midrst_load_en", load_en, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ctr_ovf", ctr_ovf, 1'b0);
        check("midrst_state", dbg_state, IDLE);
        @(negedge clk);
        rst = 1'b1;
        run_vec(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
